display_scan_ctrl: RTL and testbench
====================================

// Module: display_scan_ctrl
// PURPOSE
//   Time-multiplexing sequencer for the 4-digit seven-segment driver (seven_segment).
//   - Generates the digit scan on select[1:0] and the matching digit_val/dp per digit.
//   - Double-buffers a 4-digit BCD word so that updates never tear mid-frame.
//   - Adds per-digit blanking and blinking.
//   - Sits between game logic (writer) and the segment driver. Top level gates the driver's anode with blank.
// PARAMETERS
//   TICK_DIV      100000  src_clk cycles per digit slot (100 MHz -> 1 kHz digit rate, 250 Hz frame rate)
//   BLINK_FRAMES  64      frames per blink half-period (min 1)
// PORTS
//   src_clk      in   1   system clock; all logic on rising edge
//   src_rst_n    in   1   asynchronous, active-low reset
//   wr_en        in   1   write request; a write is accepted when wr_en && wr_ready
//   wr_data      in   16  BCD digits; [3:0] = digit 0 (select 0) ... [15:12] = digit 3
//   wr_dp        in   4   decimal-point enable per digit
//   wr_blank     in   4   force digit dark
//   wr_blink     in   4   digit blinks at the BLINK_FRAMES rate
//   wr_ready     out  1   1 = no write pending; the block can accept a write
//   select       out  2   digit index to the driver
//   digit_val    out  4   BCD value for the current digit
//   dp           out  1   decimal point for the current digit (active-high)
//   blank        out  1   1 = current digit must be dark
//   frame_start  out  1   one-cycle pulse when select wraps 3 -> 0
// BEHAVIOUR
//   Reset (async, src_rst_n = 0):
//   - prescaler = 0, select = 0, digit_val = 0, dp = 0, blank = 1.
//   - frame_start = 0, wr_ready = 1, blink phase = 0, blink frame counter = 0.
//   - active_data = 0, active_dp = 0, active_blank = 4'hF (dark until first commit), active_blink = 0.
//   - Pending registers cleared. Deasserting reset mid-frame restarts at slot 0 with no partial commit.
//   Prescaler:
//   - Counts 0..TICK_DIV-1.
//   - tick = 1 in the cycle where the count equals TICK_DIV-1; the count then returns to 0.
//   Scan:
//   - On tick, select <= select+1 (wraps 3 -> 0).
//   - digit_val, dp and blank are registered and update in the same cycle as select, so all four outputs are always coherent.
//   - frame_start is asserted in the cycle in which select becomes 0 after a wrap. It is not asserted out of reset.
//   Write FSM, two states:
//   - EMPTY (wr_ready = 1): on wr_en, latch wr_* into the pending registers and go to PENDING.
//   - PENDING (wr_ready = 0): wr_en is ignored and no data is captured.
//     On a tick with select == 3 (the wrap), copy pending -> active and go to EMPTY. wr_ready is 1 from the next cycle.
//   - Commit uses only pending data that was valid before the wrap cycle.
//     If a write is accepted in the wrap cycle itself, it commits at the following wrap.
//   - New active values first appear in the slot-0 outputs that are loaded together with the wrap.
//   - Worst-case write-to-display latency: 4*TICK_DIV + 1 cycles.
//   Blink:
//   - The frame counter increments at each wrap.
//   - When it reaches BLINK_FRAMES-1 it clears and the blink phase toggles.
//   Output equations for digit i:
//   - blank = active_blank[i] | (active_blink[i] & phase) | (active_data nibble i > 9)
//   - digit_val = active_data nibble i; it is passed through even when blank = 1.
//   - dp = active_dp[i] & ~blank.
//   Width and wrap rules:
//   - Prescaler width = $clog2(TICK_DIV); the blink counter width is sized from BLINK_FRAMES.
//   - All counters wrap silently; there is no overflow state.
// STRUCTURE
//   display_pkg:
//   - NUM_DIGITS = 4.
//   - BCD_MAX = 4'd9.
//   - wr_state_t enum {ST_EMPTY, ST_PENDING}.
//   - Helper function nibble(data, idx).
//   Sub-module refresh_prescaler:
//   - Parameter DIV; ports src_clk, src_rst_n, tick.
//   - Also reused for game timing.
//   Remainder of the block:
//   - Scan counter, shadow/active register banks, write FSM, blink counter, output register stage.
// TESTING (bench uses TICK_DIV = 4, BLINK_FRAMES = 2)
//   1. Reset, then no writes:
//      - blank = 1 in every slot.
//      - select sequence 0,1,2,3,0 with changes exactly every 4 cycles.
//      - frame_start pulses once per 16 cycles, only at select = 0.
//   2. Write wr_data = 16'h1234, dp = 4'b0100, blank = 0, blink = 0 mid-frame:
//      - wr_ready drops the next cycle.
//      - Display stays dark until the wrap, then shows 4,3,2,1 for select 0..3.
//      - dp = 1 only at select 2.
//      - wr_ready returns to 1 one cycle after the wrap.
//   3. A second write while PENDING (wr_data = 16'h9999) is ignored; after commit the display shows 16'h1234.
//   4. Write accepted in the wrap cycle:
//      - Not committed at that wrap; appears at the next wrap, 16 cycles later.
//   5. wr_blink = 4'b0001 with digit 0 = 5:
//      - Slot 0 blank toggles every 2 frames.
//      - Digit 0 dp is suppressed while blank.
//      - A nibble of 4'hA in digit 3 gives blank = 1 for slot 3.
//   6. Assert src_rst_n low with a write PENDING at select = 2:
//      - All outputs return to reset values immediately (asynchronously).
//      - The pending data is never displayed.
//      - Scan restarts at select = 0.

Source files
------------

// File: rtl/display_pkg.sv
// Shared types, constants and helpers for the display scan controller.
package display_pkg;

  localparam int         NUM_DIGITS = 4;
  localparam logic [3:0] BCD_MAX    = 4'd9;

  typedef enum logic {
    ST_EMPTY,
    ST_PENDING
  } wr_state_t;

  // Extract BCD digit idx (0 = least significant nibble) from a packed word.
  function automatic logic [3:0] nibble(input logic [4*NUM_DIGITS-1:0] data,
                                        input logic [1:0]              idx);
    return data[{idx, 2'b00} +: 4];
  endfunction

endpackage

// File: rtl/display_scan_ctrl_if.sv
// Write-side handshake between game logic (master) and the scan controller (slave).
interface display_scan_ctrl_if;

  logic                                 wr_en;
  logic [4*display_pkg::NUM_DIGITS-1:0] wr_data;
  logic [display_pkg::NUM_DIGITS-1:0]   wr_dp;
  logic [display_pkg::NUM_DIGITS-1:0]   wr_blank;
  logic [display_pkg::NUM_DIGITS-1:0]   wr_blink;
  logic                                 wr_ready;

  modport master (
    output wr_en, wr_data, wr_dp, wr_blank, wr_blink,
    input  wr_ready
  );

  modport slave (
    input  wr_en, wr_data, wr_dp, wr_blank, wr_blink,
    output wr_ready
  );

endinterface

// File: rtl/display_scan_ctrl_prescaler.sv
// Free-running divider producing a one-cycle tick every DIV clocks; also used for game timing.
module refresh_prescaler #(
  parameter int DIV = 100000
) (
  input  logic src_clk,
  input  logic src_rst_n,
  output logic tick
);

  localparam int            CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] count_q, count_d;

  // Tick on the last count of the period, then restart from zero.
  always_comb begin
    tick    = (count_q == LAST);
    count_d = tick ? '0 : count_q + 1'b1;
  end

  // Counter register.
  always_ff @(posedge src_clk or negedge src_rst_n) begin
    if (!src_rst_n) count_q <= '0;
    else            count_q <= count_d;
  end

endmodule

// File: rtl/display_scan_ctrl.sv
// Digit scan sequencer with double-buffered BCD word, per-digit blanking and blinking.
module display_scan_ctrl
  import display_pkg::*;
#(
  parameter int TICK_DIV     = 100000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic               src_clk,
  input  logic               src_rst_n,
  display_scan_ctrl_if.slave wr,
  output logic [1:0]         select,
  output logic [3:0]         digit_val,
  output logic               dp,
  output logic               blank,
  output logic               frame_start
);

  localparam int                   BLINK_W    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [BLINK_W-1:0]   BLINK_LAST = BLINK_W'(BLINK_FRAMES - 1);

  logic tick;
  logic wrap;

  wr_state_t state_q, state_d;

  logic [4*NUM_DIGITS-1:0] pend_data_q, pend_data_d, act_data_q, act_data_d;
  logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d, act_dp_q, act_dp_d;
  logic [NUM_DIGITS-1:0]   pend_blank_q, pend_blank_d, act_blank_q, act_blank_d;
  logic [NUM_DIGITS-1:0]   pend_blink_q, pend_blink_d, act_blink_q, act_blink_d;

  logic [1:0]         select_q, select_d;
  logic [3:0]         digit_val_q, digit_val_d;
  logic               dp_q, dp_d;
  logic               blank_q, blank_d;
  logic               frame_start_q, frame_start_d;
  logic [BLINK_W-1:0] frame_cnt_q, frame_cnt_d;
  logic               phase_q, phase_d;
  logic [3:0]         slot_nib;
  logic               slot_blank;

  refresh_prescaler #(.DIV(TICK_DIV)) u_prescaler (
    .src_clk   (src_clk),
    .src_rst_n (src_rst_n),
    .tick      (tick)
  );

  assign wrap        = tick & (select_q == 2'd3);
  assign wr.wr_ready = (state_q == ST_EMPTY);
  assign select      = select_q;
  assign digit_val   = digit_val_q;
  assign dp          = dp_q;
  assign blank       = blank_q;
  assign frame_start = frame_start_q;

  // Write FSM: capture into the shadow bank when empty, publish to the active bank at the frame wrap.
  always_comb begin
    state_d      = state_q;
    pend_data_d  = pend_data_q;
    pend_dp_d    = pend_dp_q;
    pend_blank_d = pend_blank_q;
    pend_blink_d = pend_blink_q;
    act_data_d   = act_data_q;
    act_dp_d     = act_dp_q;
    act_blank_d  = act_blank_q;
    act_blink_d  = act_blink_q;
    case (state_q)
      ST_EMPTY: begin
        if (wr.wr_en) begin
          pend_data_d  = wr.wr_data;
          pend_dp_d    = wr.wr_dp;
          pend_blank_d = wr.wr_blank;
          pend_blink_d = wr.wr_blink;
          state_d      = ST_PENDING;
        end
      end
      ST_PENDING: begin
        if (wrap) begin
          act_data_d  = pend_data_q;
          act_dp_d    = pend_dp_q;
          act_blank_d = pend_blank_q;
          act_blink_d = pend_blink_q;
          state_d     = ST_EMPTY;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  // Scan advance, blink timing and the coherent output stage, all loaded from next-state values.
  always_comb begin
    select_d      = select_q;
    digit_val_d   = digit_val_q;
    dp_d          = dp_q;
    blank_d       = blank_q;
    frame_start_d = 1'b0;
    frame_cnt_d   = frame_cnt_q;
    phase_d       = phase_q;
    if (wrap) begin
      frame_start_d = 1'b1;
      if (frame_cnt_q == BLINK_LAST) begin
        frame_cnt_d = '0;
        phase_d     = ~phase_q;
      end else begin
        frame_cnt_d = frame_cnt_q + 1'b1;
      end
    end
    if (tick) select_d = select_q + 2'd1;
    slot_nib   = nibble(act_data_d, select_d);
    slot_blank = act_blank_d[select_d] | (act_blink_d[select_d] & phase_d) | (slot_nib > BCD_MAX);
    if (tick) begin
      digit_val_d = slot_nib;
      blank_d     = slot_blank;
      dp_d        = act_dp_d[select_d] & ~slot_blank;
    end
  end

  // State, register banks and output registers.
  always_ff @(posedge src_clk or negedge src_rst_n) begin
    if (!src_rst_n) begin
      state_q       <= ST_EMPTY;
      pend_data_q   <= '0;
      pend_dp_q     <= '0;
      pend_blank_q  <= '0;
      pend_blink_q  <= '0;
      act_data_q    <= '0;
      act_dp_q      <= '0;
      act_blank_q   <= '1;
      act_blink_q   <= '0;
      select_q      <= 2'd0;
      digit_val_q   <= 4'd0;
      dp_q          <= 1'b0;
      blank_q       <= 1'b1;
      frame_start_q <= 1'b0;
      frame_cnt_q   <= '0;
      phase_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      pend_data_q   <= pend_data_d;
      pend_dp_q     <= pend_dp_d;
      pend_blank_q  <= pend_blank_d;
      pend_blink_q  <= pend_blink_d;
      act_data_q    <= act_data_d;
      act_dp_q      <= act_dp_d;
      act_blank_q   <= act_blank_d;
      act_blink_q   <= act_blink_d;
      select_q      <= select_d;
      digit_val_q   <= digit_val_d;
      dp_q          <= dp_d;
      blank_q       <= blank_d;
      frame_start_q <= frame_start_d;
      frame_cnt_q   <= frame_cnt_d;
      phase_q       <= phase_d;
    end
  end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Self-checking bench for display_scan_ctrl with a cycle-count based reference model.
module tb_display_scan_ctrl;
  import display_pkg::*;

  localparam int TD    = 4;
  localparam int BF    = 2;
  localparam int FRAME = 4 * TD;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  display_scan_ctrl_if wr_if ();

  logic [1:0] select;
  logic [3:0] digit_val;
  logic       dp, blank, frame_start;

  display_scan_ctrl #(.TICK_DIV(TD), .BLINK_FRAMES(BF)) dut (
    .src_clk     (clk),
    .src_rst_n   (rst_n),
    .wr          (wr_if),
    .select      (select),
    .digit_val   (digit_val),
    .dp          (dp),
    .blank       (blank),
    .frame_start (frame_start)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: n = clock edges since reset release; active/pending word banks.
  int          n;
  logic [15:0] m_act_data, m_pend_data;
  logic [3:0]  m_act_dp, m_act_blank, m_act_blink;
  logic [3:0]  m_pend_dp, m_pend_blank, m_pend_blink;
  logic        m_pend_valid;

  typedef struct {
    logic [15:0] data;
    logic [3:0]  dpv;
    logic [3:0]  blk;
    logic [3:0]  exp_blank;
    logic [3:0]  exp_dp;
  } vec_t;

  vec_t vecs[4];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %h, expected %h (edge %0d)", name, act, exp, n);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_cmp++;
    n_bad++;
    $display("[TB] FAIL %s: wait bound expired (edge %0d)", name, n);
  endtask

  task automatic model_reset();
    n            = 0;
    m_act_data   = 16'h0000;
    m_act_dp     = 4'h0;
    m_act_blank  = 4'hF;
    m_act_blink  = 4'h0;
    m_pend_valid = 1'b0;
  endtask

  // One clock edge: commits land on every FRAME-th edge, writes accepted only when nothing is pending.
  task automatic model_edge();
    bit ready_pre;
    ready_pre = !m_pend_valid;
    n++;
    if (m_pend_valid && (n % FRAME == 0)) begin
      m_act_data   = m_pend_data;
      m_act_dp     = m_pend_dp;
      m_act_blank  = m_pend_blank;
      m_act_blink  = m_pend_blink;
      m_pend_valid = 1'b0;
    end else if (ready_pre && wr_if.wr_en) begin
      m_pend_data  = wr_if.wr_data;
      m_pend_dp    = wr_if.wr_dp;
      m_pend_blank = wr_if.wr_blank;
      m_pend_blink = wr_if.wr_blink;
      m_pend_valid = 1'b1;
    end
  endtask

  task automatic check_output();
    int         slot, wraps;
    logic       ph, eb;
    logic [3:0] nib;
    slot  = (n / TD) % 4;
    wraps = n / FRAME;
    ph    = ((wraps / BF) % 2) == 1;
    nib   = m_act_data[slot*4 +: 4];
    eb    = m_act_blank[slot] | (m_act_blink[slot] & ph) | (nib > 4'd9);
    chk("select", 16'(select), 16'(slot));
    chk("digit_val", 16'(digit_val), 16'(nib));
    chk("blank", 16'(blank), 16'(eb));
    chk("dp", 16'(dp), 16'(m_act_dp[slot] & ~eb));
    chk("frame_start", 16'(frame_start), 16'((n > 0) && (n % FRAME == 0)));
    chk("wr_ready", 16'(wr_if.wr_ready), 16'(!m_pend_valid));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_output();
  endtask

  task automatic apply_stimulus(input logic en, input logic [15:0] data, input logic [3:0] dpv,
                                input logic [3:0] blk, input logic [3:0] blink);
    wr_if.wr_en    = en;
    wr_if.wr_data  = data;
    wr_if.wr_dp    = dpv;
    wr_if.wr_blank = blk;
    wr_if.wr_blink = blink;
  endtask

  task automatic write_once(input logic [15:0] data, input logic [3:0] dpv,
                            input logic [3:0] blk, input logic [3:0] blink);
    apply_stimulus(1'b1, data, dpv, blk, blink);
    step();
    wr_if.wr_en = 1'b0;
  endtask

  task automatic wait_ready(input string name);
    for (int k = 0; k < 4 * FRAME && !wr_if.wr_ready; k++) step();
    if (!wr_if.wr_ready) timeout_fail(name);
  endtask

  task automatic wait_frame(input string name);
    for (int k = 0; k < 2 * FRAME && !frame_start; k++) step();
    if (!frame_start) timeout_fail(name);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_select"}, 16'(select), 16'd0);
    chk({tag, "_digit_val"}, 16'(digit_val), 16'd0);
    chk({tag, "_dp"}, 16'(dp), 16'd0);
    chk({tag, "_blank"}, 16'(blank), 16'd1);
    chk({tag, "_frame_start"}, 16'(frame_start), 16'd0);
    chk({tag, "_wr_ready"}, 16'(wr_if.wr_ready), 16'd1);
  endtask

  initial begin
    int   pulses;
    logic b[4];

    vecs[0] = '{16'h1234, 4'b0100, 4'b0000, 4'b0000, 4'b0100};
    vecs[1] = '{16'hA905, 4'b1111, 4'b0010, 4'b1010, 4'b0101};
    vecs[2] = '{16'h0000, 4'b0000, 4'b1111, 4'b1111, 4'b0000};
    vecs[3] = '{16'h9870, 4'b1001, 4'b0100, 4'b0100, 4'b1001};

    apply_stimulus(1'b0, 16'h0, 4'h0, 4'h0, 4'h0);
    model_reset();
    rst_n = 1'b0;
    #1;
    check_reset_values("reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();

    // Idle scan: all dark, regular select stepping, one frame_start per frame.
    pulses = 0;
    for (int i = 0; i < 3 * FRAME; i++) begin
      step();
      if (frame_start) pulses++;
    end
    chk("idle_frame_pulses", 16'(pulses), 16'd3);

    // Table-driven writes: wait for commit, then walk one frame of slots.
    for (int v = 0; v < 4; v++) begin
      wait_ready("table_ready_wait");
      repeat (3) step();
      write_once(vecs[v].data, vecs[v].dpv, vecs[v].blk, 4'b0000);
      chk("table_ready_drop", 16'(wr_if.wr_ready), 16'd0);
      wait_ready("table_commit_wait");
      chk("table_commit_frame_start", 16'(frame_start), 16'd1);
      for (int s = 0; s < 4; s++) begin
        chk("table_select", 16'(select), 16'(s));
        chk("table_digit", 16'(digit_val), 16'(vecs[v].data[s*4 +: 4]));
        chk("table_blank", 16'(blank), 16'(vecs[v].exp_blank[s]));
        chk("table_dp", 16'(dp), 16'(vecs[v].exp_dp[s]));
        repeat (TD) step();
      end
    end

    // Second write while pending is ignored.
    wait_ready("pending_ready_wait");
    apply_stimulus(1'b1, 16'h1234, 4'b0100, 4'h0, 4'h0);
    step();
    wr_if.wr_data = 16'h9999;
    step();
    wr_if.wr_en = 1'b0;
    wait_ready("pending_commit_wait");
    chk("ignored_write_digit0", 16'(digit_val), 16'h4);

    // Write accepted exactly on the wrap edge commits one frame later.
    for (int k = 0; k < FRAME && ((n + 1) % FRAME != 0); k++) step();
    write_once(16'h5678, 4'h0, 4'h0, 4'h0);
    chk("wrap_write_frame_start", 16'(frame_start), 16'd1);
    chk("wrap_write_pending", 16'(wr_if.wr_ready), 16'd0);
    chk("wrap_write_not_committed", 16'(digit_val), 16'h4);
    repeat (FRAME) step();
    chk("wrap_write_committed", 16'(digit_val), 16'h8);
    chk("wrap_write_ready_back", 16'(wr_if.wr_ready), 16'd1);

    // Blink on digit 0, out-of-range nibble on digit 3.
    wait_ready("blink_ready_wait");
    write_once(16'hA005, 4'b0001, 4'b0000, 4'b0001);
    wait_ready("blink_commit_wait");
    for (int f = 0; f < 4; f++) begin
      b[f] = blank;
      chk("blink_dp_suppress", 16'(dp), 16'(!blank));
      if (f < 3) repeat (FRAME) step();
    end
    chk("blink_toggle0", 16'(b[2]), 16'(!b[0]));
    chk("blink_toggle1", 16'(b[3]), 16'(!b[1]));
    chk("blink_one_change", 16'(int'(b[0] != b[1]) + int'(b[1] != b[2])), 16'd1);
    repeat (3 * TD) step();
    chk("slot3_bad_nibble_blank", 16'(blank), 16'd1);
    chk("slot3_digit", 16'(digit_val), 16'hA);

    // Reset asserted mid-slot with a write pending at select 2.
    wait_frame("reset_frame_wait");
    write_once(16'h7777, 4'hF, 4'h0, 4'h0);
    for (int k = 0; k < FRAME && select != 2'd2; k++) step();
    chk("reset_pending_select", 16'(select), 16'd2);
    chk("reset_pending_busy", 16'(wr_if.wr_ready), 16'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_values("async_reset");
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    repeat (3 * FRAME) step();

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      apply_stimulus(($urandom % 4) == 0, 16'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
      step();
    end
    wr_if.wr_en = 1'b0;
    repeat (2 * FRAME) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
